alu_mul_seq: RTL
================

// Module: alu_mul_seq
// PURPOSE
//  Iterative shift-add multiply sequencer for the EX stage. Owns the shared ALU
//  16-bit adder (cla_16b) while a multiply runs, driving its A/B/C_in via an
//  EX-stage mux gated by adder_grant. Stalls the pipeline until the product is ready.
//  Unsigned product; the low half equals the two's-complement low half.
// PARAMETERS
//  WIDTH   16  operand width; also the iteration count
//  CNT_W   4   iteration counter width; must satisfy 2**CNT_W == WIDTH
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous reset, active-high
//  start        in   1      request multiply of src_a * src_b (level, sampled in IDLE)
//  flush        in   1      abort any in-flight multiply (branch mispredict/exception)
//  src_a        in   WIDTH  multiplicand
//  src_b        in   WIDTH  multiplier
//  adder_a      out  WIDTH  to shared adder A input (valid when adder_grant=1)
//  adder_b      out  WIDTH  to shared adder B input
//  adder_cin    out  1      to shared adder C_in; always 0
//  adder_sum    in   WIDTH  shared adder S
//  adder_cout   in   1      shared adder C_out
//  adder_grant  out  1      1 = EX mux routes sequencer onto adder; pipeline operands ignored
//  stall        out  1      hold IF/ID/EX; keep start/src_* stable
//  done         out  1      one-cycle pulse; prod_hi/prod_lo valid this cycle
//  prod_hi      out  WIDTH  upper half of product
//  prod_lo      out  WIDTH  lower half of product
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, P_hi=0, P_lo=0, mcand=0, done=0.
//   Derived outputs then read adder_grant=0 and stall=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE
//   - start & ~flush: load mcand=src_a, P_hi=0, P_lo=src_b, cnt=0; go to RUN.
//   - stall is combinationally 1 in this accept cycle.
//  RUN (WIDTH cycles)
//   - adder_grant=1, adder_a=P_hi, adder_b = P_lo[0] ? mcand : 0, adder_cin=0.
//   - Next {P_hi,P_lo} = {adder_cout, adder_sum, P_lo[WIDTH-1:1]}.
//   - cnt += 1; after cnt==WIDTH-1, go to DONE.
//  DONE
//   - done=1, stall=0, adder_grant=0; the EX instruction advances with prod_lo.
//   - Next cycle: IDLE. start in DONE is not accepted; 1-cycle turnaround.
//  Latency: start accepted at cycle T; RUN T+1..T+WIDTH; done at T+WIDTH+1.
//  stall = (IDLE & start & ~flush) | RUN.
//  adder_grant = RUN only; it is a registered-state decode and never glitches from start.
//  prod_hi/prod_lo hold their last value after DONE until the next accept.
//  Boundaries
//   - flush in RUN or DONE: IDLE next cycle. No done pulse (DONE: the pulse is
//     already out; nothing further). Product regs keep partial value; not valid.
//   - start & flush together in IDLE: flush wins, no accept.
//   - start while RUN: ignored; operands are not re-sampled.
//   - rst mid-RUN: reset values next cycle; adder_grant drops immediately
//     after that edge.
//   - cnt wrap: counter width exactly CNT_W; wrap at WIDTH-1 -> 0 coincides with
//     the RUN->DONE transition.
//   - Operand 0 on either side: still runs WIDTH cycles; no early exit.
// STRUCTURE
//  - Shared include mul_seq_defs.vh: state encodings
//    MS_IDLE=2'b00, MS_RUN=2'b01, MS_DONE=2'b10, plus MS_WIDTH.
//  - 2'b11 is illegal; it decodes to IDLE next cycle.
//  - One sub-module, mul_seq_dp: mcand/P_hi/P_lo registers and adder_b gating.
//    The top level holds the FSM, counter and output decode.
//  - The adder is NOT instantiated here; it is reused through the EX mux.
// TESTING
//  1. rst, then 3*5: prod_lo=0x000F, prod_hi=0x0000; done exactly 17 cycles after accept.
//  2. 0xFFFF*0xFFFF -> prod_hi=0xFFFE, prod_lo=0x0001; stall high 17 cycles, low on done.
//  3. 0x8000*0x0002 -> prod_hi=0x0001, prod_lo=0x0000 (carry through adder_cout).
//  4. 0x1234*0x0000 -> product 0; adder_b==0 every RUN cycle.
//  5. flush on 5th RUN cycle -> IDLE next cycle; no done, grant=0, stall=0;
//     then start & flush same cycle -> not accepted.
//  6. start toggled/changed during RUN -> result uses original operands;
//     rst on RUN cycle 8 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the EX-stage iterative multiply sequencer:
// state encodings and the default operand width.
package alu_mul_seq_pkg;

  // Default operand width; also the number of shift-add iterations.
  localparam int MS_WIDTH = 16;

  // Sequencer states. 2'b11 is never entered on purpose; it is decoded
  // back to idle so a corrupted state register recovers in one cycle.
  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_RUN  = 2'b01,
    MS_DONE = 2'b10,
    MS_ILL  = 2'b11
  } ms_state_e;

endpackage

// File: rtl/mul_seq_dp.sv
// Multiply datapath: multiplicand register and the {P_hi, P_lo} partial
// product / multiplier shift register. The adder itself lives in the ALU
// and is reached through the EX mux; this block only presents its
// operands and absorbs its result.
module mul_seq_dp
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = MS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo
);

  logic [WIDTH-1:0] mcand;

  // Operand presentation: the running upper half plus either the
  // multiplicand or zero, selected by the multiplier bit being consumed.
  always_comb begin
    adder_a = p_hi;
    adder_b = p_lo[0] ? mcand : '0;
  end

  // Load operands on accept; on each iteration shift the adder result
  // (with its carry) into the top while the consumed multiplier bit
  // falls off the bottom. Outside of load/step the registers hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else if (load) begin
      mcand <= src_a;
      p_hi  <= '0;
      p_lo  <= src_b;
    end else if (step) begin
      {p_hi, p_lo} <= {adder_cout, adder_sum, p_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// EX-stage iterative shift-add multiply sequencer. Borrows the shared ALU
// adder for WIDTH cycles per multiply and stalls the pipeline until the
// unsigned product is ready. CNT_W must satisfy 2**CNT_W == WIDTH so the
// iteration counter wraps to zero exactly as the last iteration retires.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = MS_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic             adder_grant,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ms_state_e        state_q;
  ms_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dp_load;
  logic             dp_step;

  // Next-state, counter and datapath-enable decode. Flush beats start in
  // idle and aborts a running multiply without producing a done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (start && !flush) begin
          state_d = MS_RUN;
          cnt_d   = '0;
          dp_load = 1'b1;
        end
      end
      MS_RUN: begin
        if (flush) begin
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else begin
          dp_step = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = MS_DONE;
          end
        end
      end
      MS_DONE: begin
        // One-cycle turnaround: a start held here is seen again in idle.
        state_d = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and iteration counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode. Grant comes only from the registered state so the EX
  // mux never sees a glitch from the start input; stall additionally
  // covers the accept cycle so the pipeline freezes as operands load.
  always_comb begin
    adder_grant = (state_q == MS_RUN);
    done        = (state_q == MS_DONE);
    stall       = ((state_q == MS_IDLE) && start && !flush) || (state_q == MS_RUN);
    adder_cin   = 1'b0;
  end

  mul_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (dp_load),
    .step      (dp_step),
    .src_a     (src_a),
    .src_b     (src_b),
    .adder_sum (adder_sum),
    .adder_cout(adder_cout),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .p_hi      (prod_hi),
    .p_lo      (prod_lo)
  );

endmodule
